// File: rtl/hpdcache_params_pkg.sv
// Shared HPDcache build constants used to size the response-path FIFOs.
package hpdcache_params_pkg;

  localparam int unsigned PARAM_REQ_WORDS                   = 2;
  localparam int unsigned PARAM_WORD_WIDTH                  = 64;
  localparam int unsigned PARAM_REFILL_FIFO_DEPTH           = 2;
  localparam bit          PARAM_REFILL_CORE_RSP_FEEDTHROUGH = 1'b1;
  localparam int unsigned PARAM_RSP_FIFO_AF_THRESH          = PARAM_REFILL_FIFO_DEPTH - 1;

endpackage

// File: rtl/hpdcache_rsp_fifo.sv
// Response FIFO between the refill/response path and the core response channel,
// with optional empty-bypass, occupancy/almost-full reporting, flush and sticky overflow.
module hpdcache_rsp_fifo
  import hpdcache_params_pkg::*;
#(
  parameter int unsigned DEPTH       = PARAM_REFILL_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH  = PARAM_REQ_WORDS * PARAM_WORD_WIDTH,
  parameter bit          FEEDTHROUGH = PARAM_REFILL_CORE_RSP_FEEDTHROUGH,
  parameter int unsigned AF_THRESH   = DEPTH - 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         w_i,
  output logic                         wok_o,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic                         r_i,
  output logic                         rok_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         ovf_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  empty, full, bypass, store, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    rok_o   = !empty || (FEEDTHROUGH && w_i);
    wok_o   = !full || (FEEDTHROUGH && r_i);
    rdata_o = (FEEDTHROUGH && empty) ? wdata_i : mem_q[rptr_q];
    // An empty-FIFO word read in the same cycle goes straight through, never stored.
    bypass  = FEEDTHROUGH && empty && w_i && r_i;
    store   = w_i && wok_o && !bypass;
    pop     = r_i && !empty;
    count_o       = count_q;
    almost_full_o = (count_q >= CW'(AF_THRESH));
    ovf_err_o     = ovf_q;
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q || (w_i && !wok_o);
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (store) wptr_d = ptr_inc(wptr_q);
      if (pop)   rptr_d = ptr_inc(rptr_q);
      if (store && !pop)      count_d = count_q + CW'(1);
      else if (!store && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (store && full) |-> (FEEDTHROUGH && r_i));

  if (!FEEDTHROUGH) begin : g_reg_checks
    a_rok_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rok_o && !r_i && !flush_i) |=> rok_o);
  end

endmodule

// File: tb/tb_hpdcache_rsp_fifo.sv
// Bench for hpdcache_rsp_fifo: four configurations driven from a vector table and
// hand sequences, with read data checked against a queue-based scoreboard.
module tb_hpdcache_rsp_fifo;

  typedef struct {
    int          sel;
    bit          w;
    logic [15:0] wd;
    bit          r;
    bit          fl;
    bit          e_rok;
    bit          e_wok;
    int          e_cnt;
    bit          e_af;
    bit          e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        w [4];
  logic        r [4];
  logic        fl [4];
  logic [15:0] wd [4];

  logic        rok0, rok1, rok2, rok3, wok0, wok1, wok2, wok3;
  logic        af0, af1, af2, af3, ov0, ov1, ov2, ov3;
  logic [15:0] rd0, rd1, rd2, rd3;
  logic [1:0]  c0, c1, c3;
  logic [2:0]  c2;

  hpdcache_rsp_fifo #(.DEPTH(2), .DATA_WIDTH(16), .FEEDTHROUGH(1'b0)) u_ft0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]), .w_i(w[0]), .wok_o(wok0), .wdata_i(wd[0]),
    .r_i(r[0]), .rok_o(rok0), .rdata_o(rd0), .count_o(c0), .almost_full_o(af0), .ovf_err_o(ov0));
  hpdcache_rsp_fifo #(.DEPTH(2), .DATA_WIDTH(16), .FEEDTHROUGH(1'b1)) u_ft1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]), .w_i(w[1]), .wok_o(wok1), .wdata_i(wd[1]),
    .r_i(r[1]), .rok_o(rok1), .rdata_o(rd1), .count_o(c1), .almost_full_o(af1), .ovf_err_o(ov1));
  hpdcache_rsp_fifo #(.DEPTH(4), .DATA_WIDTH(16), .FEEDTHROUGH(1'b0), .AF_THRESH(3)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]), .w_i(w[2]), .wok_o(wok2), .wdata_i(wd[2]),
    .r_i(r[2]), .rok_o(rok2), .rdata_o(rd2), .count_o(c2), .almost_full_o(af2), .ovf_err_o(ov2));
  hpdcache_rsp_fifo #(.DEPTH(3), .DATA_WIDTH(16), .FEEDTHROUGH(1'b0)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[3]), .w_i(w[3]), .wok_o(wok3), .wdata_i(wd[3]),
    .r_i(r[3]), .rok_o(rok3), .rdata_o(rd3), .count_o(c3), .almost_full_o(af3), .ovf_err_o(ov3));

  int total = 0;
  int bad   = 0;
  logic [15:0] sb [$];
  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input bit wv, input logic [15:0] d, input bit rv,
                              input bit f, input bit erok, input bit ewok, input int ecnt,
                              input bit eaf, input bit eovf);
    vec_t v;
    v.sel = sel; v.w = wv; v.wd = d; v.r = rv; v.fl = f;
    v.e_rok = erok; v.e_wok = ewok; v.e_cnt = ecnt; v.e_af = eaf; v.e_ovf = eovf;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    logic orok, owok, oaf, oov;
    logic [15:0] ord;
    int ocnt;
    logic [15:0] exp_d;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      w[i] = 1'b0; r[i] = 1'b0; fl[i] = 1'b0; wd[i] = '0;
    end
    w[v.sel] = v.w; r[v.sel] = v.r; fl[v.sel] = v.fl; wd[v.sel] = v.wd;
    #1;
    case (v.sel)
      0:       begin orok = rok0; owok = wok0; oaf = af0; oov = ov0; ord = rd0; ocnt = int'(c0); end
      1:       begin orok = rok1; owok = wok1; oaf = af1; oov = ov1; ord = rd1; ocnt = int'(c1); end
      2:       begin orok = rok2; owok = wok2; oaf = af2; oov = ov2; ord = rd2; ocnt = int'(c2); end
      default: begin orok = rok3; owok = wok3; oaf = af3; oov = ov3; ord = rd3; ocnt = int'(c3); end
    endcase
    chk({tag, " rok"},   int'(orok), int'(v.e_rok));
    chk({tag, " wok"},   int'(owok), int'(v.e_wok));
    chk({tag, " count"}, ocnt,       v.e_cnt);
    chk({tag, " af"},    int'(oaf),  int'(v.e_af));
    chk({tag, " ovf"},   int'(oov),  int'(v.e_ovf));
    if (v.fl) begin
      sb.delete();
    end else begin
      if (v.w && v.e_wok) sb.push_back(v.wd);
      if (v.r && v.e_rok) begin
        if (sb.size() == 0) begin
          chk({tag, " sb_underflow"}, 1, 0);
        end else begin
          exp_d = sb.pop_front();
          chk({tag, " rdata"}, int'(ord), int'(exp_d));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, reads;
    bit wv, rv;
    for (int i = 0; i < 4; i++) begin
      w[i] = 1'b0; r[i] = 1'b0; fl[i] = 1'b0; wd[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst wok0", int'(wok0), 1);
    chk("rst rok0", int'(rok0), 0);
    chk("rst cnt0", int'(c0), 0);
    chk("rst af0",  int'(af0), 0);
    chk("rst ovf0", int'(ov0), 0);
    chk("rst rok1", int'(rok1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // DEPTH=2, registered: fill, overflow, drain in order
    tbl.push_back(mk(0, 1, 16'h00A0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 16'h00B0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 16'h00C0, 0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1));
    // DEPTH=2, feedthrough: bypass, then full with simultaneous read/write
    tbl.push_back(mk(1, 1, 16'hCAFE, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0011, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0022, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16'h0033, 1, 0, 1, 1, 2, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 2, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 2, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0));
    // DEPTH=4, AF_THRESH=3: almost-full edge, then flush with a write in the same cycle
    tbl.push_back(mk(2, 1, 16'h0041, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 1, 16'h0042, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2, 1, 16'h0043, 0, 0, 1, 1, 2, 0, 0));
    tbl.push_back(mk(2, 0, 16'h0000, 0, 0, 1, 1, 3, 1, 0));
    tbl.push_back(mk(2, 0, 16'h0000, 1, 0, 1, 1, 3, 1, 0));
    tbl.push_back(mk(2, 0, 16'h0000, 0, 0, 1, 1, 2, 0, 0));
    tbl.push_back(mk(2, 1, 16'h0044, 0, 0, 1, 1, 2, 0, 0));
    tbl.push_back(mk(2, 1, 16'h0045, 0, 1, 1, 1, 3, 1, 0));
    tbl.push_back(mk(2, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 1, 16'h0046, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 0, 16'h0000, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(2, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // DEPTH=3 wrap-around: interleaved writes of 1..10 with reads, order checked by scoreboard
    sb.delete();
    nxt = 1;
    reads = 0;
    for (int k = 0; k < 60 && (nxt <= 10 || sb.size() > 0); k++) begin
      wv = (nxt <= 10) && (sb.size() < 3) && ((k % 4) != 3);
      rv = ((k % 2) == 1) || (nxt > 10);
      if (rv && sb.size() > 0) reads++;
      step(mk(3, wv, 16'(nxt), rv, 0, sb.size() > 0, sb.size() < 3, sb.size(), sb.size() >= 2, 0),
           $sformatf("wrap%0d", k));
      if (wv) nxt++;
    end
    chk("wrap reads", reads, 10);

    // Reset mid-stream: stored words vanish immediately, sticky overflow clears
    step(mk(3, 1, 16'h0077, 0, 0, 0, 1, 0, 0, 0), "rst_w0");
    step(mk(3, 1, 16'h0078, 0, 0, 1, 1, 1, 0, 0), "rst_w1");
    @(negedge clk);
    for (int i = 0; i < 4; i++) w[i] = 1'b0;
    #1;
    chk("pre-rst cnt3", int'(c3), 2);
    chk("pre-rst ovf0", int'(ov0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst cnt3", int'(c3), 0);
    chk("mid-rst wok3", int'(wok3), 1);
    chk("mid-rst rok3", int'(rok3), 0);
    chk("mid-rst ovf0", int'(ov0), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(3, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpdcache_rsp_fifo.md
# hpdcache_rsp_fifo

- Parametrised response FIFO between the HPDcache refill/response path and the core response channel.
- Generalises the fixed two-entry refill FIFO:
  - configurable depth and data width;
  - a compile-time feedthrough (bypass) mode;
  - an occupancy counter, an almost-full flag, a synchronous flush and a sticky overflow error.
- One instance per response channel; typically instantiated with `PARAM_REFILL_FIFO_DEPTH` and `PARAM_REFILL_CORE_RSP_FEEDTHROUGH`.

## Interface
Parameters:
- `DEPTH`, default 2: number of storage entries, ≥1.
- `DATA_WIDTH`, default 128: payload width in bits (`PARAM_REQ_WORDS*PARAM_WORD_WIDTH`).
- `FEEDTHROUGH`, default 1:
  - 1 = empty-bypass and write-while-full-with-read allowed;
  - 0 = fully registered.
- `AF_THRESH`, default `DEPTH-1`: `almost_full_o` asserts when occupancy ≥ this value; legal range 1..`DEPTH`.

Ports:
- `clk_i`  in  1  clock; one clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of all entries.
- `w_i`  in  1  write valid.
- `wok_o`  out  1  write ready.
- `wdata_i`  in  `DATA_WIDTH`  write payload.
- `r_i`  in  1  read ready from consumer.
- `rok_o`  out  1  read valid.
- `rdata_o`  out  `DATA_WIDTH`  read payload.
- `count_o`  out  `$clog2(DEPTH+1)`  stored entries; excludes bypassed data.
- `almost_full_o`  out  1  `count_o` ≥ `AF_THRESH`.
- `ovf_err_o`  out  1  sticky: `w_i` seen while `wok_o`=0; cleared only by reset.

## Operation
Storage and handshakes:
- Circular buffer with read pointer, write pointer and count; pointers wrap from `DEPTH-1` to 0.
- A write is accepted when `w_i && wok_o`; a read completes when `r_i && rok_o`.

`FEEDTHROUGH`=0:
- `wok_o` = (count < `DEPTH`).
- `rok_o` = (count > 0).
- `rdata_o` = entry at the read pointer.
- No combinational path from `w_i`/`r_i` to any output.

`FEEDTHROUGH`=1:
- `rok_o` = (count > 0) || `w_i`.
- When count = 0, `rdata_o` = `wdata_i`.
  - If `r_i` is also high, the word is consumed with no storage and no count change.
  - Otherwise it is stored.
- `wok_o` = (count < `DEPTH`) || `r_i`, so a simultaneous read frees a slot.
- Combinational paths `w_i`→`rok_o` and `r_i`→`wok_o` are intentional.

Count update:
- count_next = count + accepted_store − stored_read.
- Simultaneous store and read of stored data leaves the count unchanged; both pointers advance.

Flush:
- `flush_i` has priority: pointers and count go to 0 next cycle.
- A write or read in the flush cycle is ignored for state purposes.
- Outputs are still computed combinationally from the current state.

Overflow:
- `ovf_err_o` sets on any cycle with `w_i`=1 and `wok_o`=0.
- The write is dropped and the FIFO is unchanged.

Reset values: `wok_o`=1, `rok_o`=0 (FEEDTHROUGH=0) or `w_i` (FEEDTHROUGH=1), `count_o`=0, `almost_full_o`=0, `ovf_err_o`=0, `rdata_o`=don't-care.

Reset mid-operation:
- All stored data is discarded immediately on the `rst_ni` falling edge.
- Storage RAM contents are not cleared; they are never read while count=0.

## Timing
- `FEEDTHROUGH`=0: write→`rok_o` latency is 1 cycle; read→`wok_o` recovery is 1 cycle.
- `FEEDTHROUGH`=1, empty FIFO: write→`rok_o` latency is 0 cycles.
- `FEEDTHROUGH`=1, non-empty FIFO: strict FIFO order; bypass never overtakes stored data.
- `DEPTH`=1 is legal: pointers are a constant 0.
- Full throughput: one write and one read per cycle at steady state.

## Structure
- Constants stay in `hpdcache_params_pkg`; add `PARAM_RSP_FIFO_AF_THRESH`.
- No typedefs are needed; the payload is a flat vector.
- No sub-module: pointer/count logic and a flop array are implemented inline.
- SVA in the same file:
  - count ≤ `DEPTH`;
  - no push when full unless `r_i` (FEEDTHROUGH=1);
  - `rok_o` stable until `r_i` when `FEEDTHROUGH`=0.

## Test plan
- `DEPTH`=2, FT=0: write `A`,`B` with `r_i`=0 → `count_o`=2, `wok_o`=0; a third write sets `ovf_err_o`; read → `A` then `B`.
- `DEPTH`=2, FT=1, empty: `w_i`=1, `r_i`=1, `wdata_i`=`0xCAFE` → `rdata_o`=`0xCAFE` same cycle; `count_o` stays 0.
- `DEPTH`=2, FT=1, full: `w_i`=1, `r_i`=1 → `wok_o`=1, oldest entry out, `count_o` stays 2, no overflow.
- `DEPTH`=4, `AF_THRESH`=3: three writes → `almost_full_o`=1 after the third edge; one read → 0.
- Holding 3 entries: `flush_i` pulse with `w_i`=1 → next cycle `count_o`=0, `rok_o`=0, written data discarded.
- Wrap-around, `DEPTH`=3, FT=0: 10 interleaved writes/reads of 1..10 → read order 1..10. Then assert `rst_ni` low mid-stream → `count_o`=0 and `wok_o`=1 immediately.
